// File: rtl/npu_sram_port_arbiter.sv
// ============================================================================
// Module   : npu_sram_port_arbiter
// Purpose  : Shares port 2 of the NPU 4096x16 dual-port scratch SRAM among
//            three NPU requesters (0 = weight fetch, 1 = activation fetch,
//            2 = result writeback). Whole bursts are granted round-robin,
//            beat addresses are sequenced here, and the SRAM's one-cycle
//            read latency is absorbed so that read data and completion
//            strobes are returned to the owning requester.
// Ports    : clk, reset_n          clock, asynchronous active-low reset
//            req/req_wr/req_addr/req_len   per-requester burst descriptors
//            w_data/w_valid/w_ack  per-requester write-beat handshake
//            rd_data/rd_valid      read return (data broadcast, valid one-hot)
//            grant/done/busy       burst ownership and completion
//            sram_*                SRAM port-2 Avalon-style master
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module npu_sram_port_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            req,
    input  logic [2:0]            req_wr,
    input  logic [3*ADDR_W-1:0]   req_addr,
    input  logic [3*LEN_W-1:0]    req_len,
    input  logic [3*DATA_W-1:0]   w_data,
    input  logic [2:0]            w_valid,
    output logic [2:0]            w_ack,
    output logic [DATA_W-1:0]     rd_data,
    output logic [2:0]            rd_valid,
    output logic [2:0]            grant,
    output logic [2:0]            done,
    output logic                  busy,
    output logic [ADDR_W-1:0]     sram_address,
    output logic                  sram_chipselect,
    output logic                  sram_write,
    output logic [1:0]            sram_byteenable,
    output logic [DATA_W-1:0]     sram_writedata,
    input  logic [DATA_W-1:0]     sram_readdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [2:0]        r_grant, w_grant_nxt;
    logic [1:0]        r_gidx, w_gidx_nxt;
    logic [1:0]        r_ptr, w_ptr_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [LEN_W-1:0]  r_left, w_left_nxt;
    logic              r_wr, w_wr_nxt;
    logic [2:0]        r_rd_valid, w_rd_valid_nxt;
    logic [2:0]        r_done, w_done_nxt;

    // Round-robin pick: rotate the request vector so bit 0 is the pointer
    // position, take the lowest set bit, then rotate the index back.
    logic [2:0] w_rot;
    logic [1:0] w_off;
    logic [2:0] w_sum;
    logic [1:0] w_win;
    logic [1:0] w_ptr_adv;

    always_comb begin
        case (r_ptr)
            2'd1:    w_rot = {req[0], req[2], req[1]};
            2'd2:    w_rot = {req[1], req[0], req[2]};
            default: w_rot = req;
        endcase
        if (w_rot[0])      w_off = 2'd0;
        else if (w_rot[1]) w_off = 2'd1;
        else               w_off = 2'd2;
        w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
        w_win     = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[1:0];
        w_ptr_adv = (w_win == 2'd2) ? 2'd0 : w_win + 2'd1;
    end

    logic w_beat;

    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_gidx_nxt      = r_gidx;
        w_ptr_nxt       = r_ptr;
        w_addr_nxt      = r_addr;
        w_left_nxt      = r_left;
        w_wr_nxt        = r_wr;
        w_rd_valid_nxt  = 3'b000;
        w_done_nxt      = 3'b000;
        w_beat          = 1'b0;
        w_ack           = 3'b000;
        sram_chipselect = 1'b0;
        sram_write      = 1'b0;
        sram_address    = '0;
        sram_writedata  = '0;

        case (r_state)
            ST_IDLE: begin
                // The cycle carrying a write's done pulse is held off from
                // arbitration so every burst type leaves one idle cycle
                // between its done cycle and the next grant.
                if ((req != 3'b000) && (r_done == 3'b000)) begin
                    w_grant_nxt = 3'b001 << w_win;
                    w_gidx_nxt  = w_win;
                    w_ptr_nxt   = w_ptr_adv;
                    w_addr_nxt  = req_addr[int'(w_win)*ADDR_W +: ADDR_W];
                    w_left_nxt  = req_len[int'(w_win)*LEN_W +: LEN_W];
                    w_wr_nxt    = req_wr[w_win];
                    w_state_nxt = ST_BURST;
                end
            end

            ST_BURST: begin
                // Reads issue every cycle; writes wait for the owner's data.
                w_beat = !r_wr || w_valid[r_gidx];
                if (w_beat) begin
                    sram_chipselect = 1'b1;
                    sram_write      = r_wr;
                    sram_address    = r_addr;
                    if (r_wr) begin
                        sram_writedata = w_data[int'(r_gidx)*DATA_W +: DATA_W];
                        w_ack          = r_grant;
                    end else begin
                        w_rd_valid_nxt = r_grant;
                    end
                    w_addr_nxt = r_addr + ADDR_W'(1);
                    w_left_nxt = r_left - LEN_W'(1);
                    if (r_left == '0) begin
                        // The final read word returns in DRAIN, alongside done.
                        w_done_nxt = r_grant;
                        if (r_wr) begin
                            w_grant_nxt = 3'b000;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_DRAIN;
                        end
                    end
                end
            end

            ST_DRAIN: begin
                w_grant_nxt = 3'b000;
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_grant_nxt = 3'b000;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_grant    <= 3'b000;
            r_gidx     <= 2'd0;
            r_ptr      <= 2'd0;
            r_addr     <= '0;
            r_left     <= '0;
            r_wr       <= 1'b0;
            r_rd_valid <= 3'b000;
            r_done     <= 3'b000;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_gidx     <= w_gidx_nxt;
            r_ptr      <= w_ptr_nxt;
            r_addr     <= w_addr_nxt;
            r_left     <= w_left_nxt;
            r_wr       <= w_wr_nxt;
            r_rd_valid <= w_rd_valid_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign grant           = r_grant;
    assign done            = r_done;
    assign rd_valid        = r_rd_valid;
    assign rd_data         = (r_rd_valid != 3'b000) ? sram_readdata : '0;
    assign busy            = (r_state != ST_IDLE);
    assign sram_byteenable = sram_chipselect ? 2'b11 : 2'b00;

    a_grant_onehot:    assert property (@(posedge clk) disable iff (!reset_n) $onehot0(grant));
    a_rd_valid_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(rd_valid));
    a_done_onehot:     assert property (@(posedge clk) disable iff (!reset_n) $onehot0(done));
    a_w_ack_onehot:    assert property (@(posedge clk) disable iff (!reset_n) $onehot0(w_ack));
    a_cs_in_burst:     assert property (@(posedge clk) disable iff (!reset_n)
                                        sram_chipselect |-> (r_state == ST_BURST));

endmodule

`default_nettype wire

// File: doc/npu_sram_port_arbiter.md
Name: npu_sram_port_arbiter

Overview:
- Shares port 2 of the NPU 4096x16 dual-port scratch SRAM between three NPU-side requesters: 0 = weight fetch, 1 = activation fetch, 2 = result writeback.
- Port 1 stays with the HPS/Avalon side.
- Grants whole bursts round-robin, sequences the beat addresses and handles the SRAM's one-cycle read latency.
- Returns read data and completion strobes to the owning requester.

Parameters:
- ADDR_W, 12, SRAM word-address width (4096 words).
- DATA_W, 16, SRAM data width.
- LEN_W, 8, burst-length field width; beats = len+1 (1..256).

Ports:
- clk  in  1  single system clock.
- reset_n  in  1  asynchronous active-low reset.
- req  in  3  per-requester burst request (level).
- req_wr  in  3  per-requester direction: 1 = write, 0 = read.
- req_addr  in  3*ADDR_W  per-requester start word address; lane i = bits [i*ADDR_W +: ADDR_W].
- req_len  in  3*LEN_W  per-requester beat count minus 1.
- w_data  in  3*DATA_W  per-requester write data lanes.
- w_valid  in  3  per-requester write data valid.
- w_ack  out  3  one-hot; write beat consumed this cycle.
- rd_data  out  DATA_W  read data, broadcast to all requesters.
- rd_valid  out  3  one-hot; rd_data valid for that requester.
- grant  out  3  one-hot owner of the current burst.
- done  out  3  one-hot single-cycle burst-complete pulse.
- busy  out  1  arbiter not idle.
- sram_address  out  ADDR_W  SRAM port-2 address.
- sram_chipselect  out  1  SRAM port-2 select.
- sram_write  out  1  SRAM port-2 write.
- sram_byteenable  out  2  constant 2'b11 while selected, else 0.
- sram_writedata  out  DATA_W  SRAM port-2 write data.
- sram_readdata  in  DATA_W  SRAM port-2 read data; valid the cycle after the address is presented.

Behaviour:
- Reset (async, reset_n=0):
  - State = IDLE; all outputs 0.
  - Round-robin pointer = 0; internal counters cleared.
  - Reset asserted mid-burst aborts the burst immediately. No done or rd_valid is issued afterwards, and an in-flight read is discarded.
- States: IDLE, BURST, DRAIN.
- IDLE:
  - When req != 0, pick the first set bit scanning from the pointer upward, wrapping 2→0.
  - Latch that requester's addr, len and wr; set grant one-hot (registered, visible next cycle).
  - Go to BURST and advance the pointer to winner+1 mod 3.
  - busy=0 only in IDLE.
- BURST: one beat per cycle, presented combinationally from registers.
  - Read: every cycle drive sram_chipselect=1, sram_write=0, sram_address=cur_addr.
  - Write: beat issues only when w_valid[g]=1. Then drive chipselect=1, write=1, writedata=w_data lane g, and pulse w_ack[g]. When w_valid[g]=0, chipselect=0 (stall, no beat).
  - On each issued beat: cur_addr ← cur_addr+1 mod 2^ADDR_W (0xFFF wraps to 0x000), beats_left ← beats_left−1.
  - Last beat of a read → go to DRAIN.
  - Last beat of a write → pulse done[g] next cycle, clear grant, go to IDLE.
- Read return: rd_valid[g]=1 and rd_data=sram_readdata exactly one cycle after each read beat.
- DRAIN (1 cycle):
  - Last rd_valid[g] asserts together with done[g]; grant clears; go to IDLE.
- Requester obligations:
  - req and its fields are sampled only in IDLE.
  - A req dropped mid-burst does not stop the burst.
  - A req held after done re-enters arbitration as a new burst.
- Throughput: a back-to-back burst costs one idle cycle between the done cycle and the next grant.
  - Read of N beats: req seen at t → grant t+1, beats t+1..t+N, rd_valid t+2..t+N+1, done t+N+1.
- Fairness: simultaneous requests are served in pointer order. With all three asserting continuously, the grant order is strictly 0,1,2,0,…
- Invariants (assertions): grant, rd_valid, done and w_ack each at most one-hot. sram_chipselect=0 outside BURST. No beat count exceeds len+1.

Test Plan:
- Single read burst: req[1] with addr=0x010, len=3, SRAM preloaded so mem[k]=k → grant=010 one cycle later; addresses 0x010..0x013 on consecutive cycles; rd_valid[1] with data 0x0010..0x0013; done[1] with the last word; busy drops the next cycle.
- Write burst with stalls: req[2] with wr=1, addr=0x100, len=4, w_valid toggling 1,0,1,1,0,1,1 → exactly 5 w_ack pulses, writes only in w_valid cycles, mem[0x100..0x104] = supplied data, done[2] the cycle after the 5th beat.
- Round-robin: all three req asserted with len=0 → grants 0,1,2,0,1,2, each separated by one idle cycle. Then only req[0] asserted after winner 2 → granted immediately.
- Wrap-around: read addr=0xFFE, len=3 → sram_address sequence 0xFFE, 0xFFF, 0x000, 0x001.
- Single beat (len=0) read and write → exactly one SRAM access each; read done coincides with its rd_valid.
- Reset mid-burst: reset_n low during beat 3 of a len=7 read → all outputs 0 asynchronously, no done. After release, req[2] pending with req[0] also asserted → req[0] wins (pointer reset to 0).
